// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared limits, edit state enum and field encodings for time setting
package alarm_clock_pkg;

  localparam logic [7:0] MAX_HR  = 8'd23;
  localparam logic [7:0] MAX_MIN = 8'd59;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT_HR  = 2'd1,
    EDIT_MIN = 2'd2,
    COMMIT   = 2'd3
  } set_state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HRS  = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  // Step a time field by one, wrapping to zero past its maximum.
  function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] max_value);
    return (value == max_value) ? 8'd0 : value + 8'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - valid/ready load channel from the time setter to a counter
interface time_set_ctrl_if;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_hrs;
  logic [7:0] load_min;

  modport master (output load_valid, output load_hrs, output load_min, input load_ready);
  modport slave  (input load_valid, input load_hrs, input load_min, output load_ready);
endinterface

// File: rtl/time_set_ctrl_key_debounce.sv
// rtl/time_set_ctrl_key_debounce.sv - key synchronizer, debounce counter and press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          sample_pressed;

  assign sample_pressed = ~sync2;

  // Two-flop synchronizer; idles at the released (high) level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after a full run of differing samples; pulse on a new press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sample_pressed == pressed) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt     <= '0;
        pressed <= sample_pressed;
        press   <= sample_pressed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - key-driven hour/minute editor with load handshake; option AUTO_REPEAT_EN
module time_set_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  key_mode_n,
  input  logic                  key_inc_n,
  input  logic [7:0]            cur_hrs,
  input  logic [7:0]            cur_min,
  time_set_ctrl_if.master       load,
  output logic                  editing,
  output logic [1:0]            edit_field,
  output logic [7:0]            edit_hrs,
  output logic [7:0]            edit_min
);

  set_state_t state;
  set_state_t state_next;
  logic       mode_pulse;
  logic       mode_level_unused;
  logic       inc_pulse;
  logic       inc_level;
  logic       inc_evt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_mode_n),
    .pressed (mode_level_unused),
    .press   (mode_pulse)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_inc_n),
    .pressed (inc_level),
    .press   (inc_pulse)
  );

`ifdef AUTO_REPEAT_EN
  logic [15:0] rep_cnt;
  logic        rep_fire;

  // rep_cnt equals the cycles elapsed since the press pulse; after each repeat it is
  // rewound so the next repeat lands REPEAT_RATE cycles later.
  assign rep_fire = inc_level && (rep_cnt == 16'(REPEAT_DELAY));

  // Repeat counter runs only while the inc key is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt <= '0;
    end else if (!inc_level) begin
      rep_cnt <= '0;
    end else if (rep_fire) begin
      rep_cnt <= 16'(REPEAT_DELAY - REPEAT_RATE + 1);
    end else begin
      rep_cnt <= rep_cnt + 16'd1;
    end
  end

  assign inc_evt = inc_pulse | rep_fire;
`else
  logic unused_repeat;
  assign unused_repeat = inc_level & (REPEAT_DELAY > 0) & (REPEAT_RATE > 0);
  assign inc_evt = inc_pulse;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: mode advances the edit sequence; COMMIT leaves on a completed transfer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (mode_pulse) state_next = EDIT_HR;
      EDIT_HR:  if (mode_pulse) state_next = EDIT_MIN;
      EDIT_MIN: if (mode_pulse) state_next = COMMIT;
      COMMIT:   if (load.load_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; load data mirrors the working values, frozen in COMMIT.
  always_comb begin
    editing         = 1'b0;
    edit_field      = FIELD_NONE;
    load.load_valid = 1'b0;
    load.load_hrs   = edit_hrs;
    load.load_min   = edit_min;
    case (state)
      EDIT_HR: begin
        editing    = 1'b1;
        edit_field = FIELD_HRS;
      end
      EDIT_MIN: begin
        editing    = 1'b1;
        edit_field = FIELD_MIN;
      end
      COMMIT:  load.load_valid = 1'b1;
      default: ;
    endcase
  end

  // Working values: capture with range clamp on entry, wrap-increment in the active field.
  // A mode pulse in the same cycle suppresses the increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edit_hrs <= 8'd0;
      edit_min <= 8'd0;
    end else if (state == IDLE && mode_pulse) begin
      edit_hrs <= (cur_hrs > MAX_HR)  ? 8'd0 : cur_hrs;
      edit_min <= (cur_min > MAX_MIN) ? 8'd0 : cur_min;
    end else if (!mode_pulse && inc_evt) begin
      if (state == EDIT_HR)  edit_hrs <= wrap_inc(edit_hrs, MAX_HR);
      if (state == EDIT_MIN) edit_min <= wrap_inc(edit_min, MAX_MIN);
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_mode_n;
  logic       key_inc_n;
  logic [7:0] cur_hrs;
  logic [7:0] cur_min;
  logic       editing;
  logic [1:0] edit_field;
  logic [7:0] edit_hrs;
  logic [7:0] edit_min;
  int         checks = 0;
  int         failures = 0;
  int         xfers = 0;
  int         exp_rep;

  time_set_ctrl_if load_bus ();

  time_set_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_mode_n (key_mode_n),
    .key_inc_n  (key_inc_n),
    .cur_hrs    (cur_hrs),
    .cur_min    (cur_min),
    .load       (load_bus),
    .editing    (editing),
    .edit_field (edit_field),
    .edit_hrs   (edit_hrs),
    .edit_min   (edit_min)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_bus.load_valid && load_bus.load_ready) xfers <= xfers + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Clean press of the selected keys, held 20 cycles, then released and settled.
  task automatic press(input bit mode, input bit inc);
    if (mode) key_mode_n = 1'b0;
    if (inc)  key_inc_n  = 1'b0;
    step(20);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    step(22);
  endtask

  initial begin
    reset_n             = 1'b0;
    key_mode_n          = 1'b1;
    key_inc_n           = 1'b1;
    cur_hrs             = 8'd14;
    cur_min             = 8'd30;
    load_bus.load_ready = 1'b0;
    step(3);
    check("rst_valid", load_bus.load_valid, 0);
    check("rst_editing", editing, 0);
    check("rst_field", edit_field, 0);
    check("rst_hrs", edit_hrs, 0);
    check("rst_min", edit_min, 0);
    check("rst_load_hrs", load_bus.load_hrs, 0);
    reset_n = 1'b1;
    step(2);

    // Enter edit: pulse after 2 + 16 edges, state one edge later.
    key_mode_n = 1'b0;
    step(18);
    check("enter_latency_early", editing, 0);
    step(1);
    check("enter_editing", editing, 1);
    check("enter_field", edit_field, 2'b01);
    check("enter_hrs", edit_hrs, 14);
    check("enter_min", edit_min, 30);
    key_mode_n = 1'b1;
    step(22);

    // Short bounces never reach the debounce threshold.
    repeat (4) begin
      key_inc_n = 1'b0;
      step(3);
      key_inc_n = 1'b1;
      step(3);
    end
    step(20);
    check("bounce_hrs", edit_hrs, 14);
    check("bounce_field", edit_field, 2'b01);
    press(1'b0, 1'b1);
    check("clean_press_hrs", edit_hrs, 15);

    // Commit with the counter stalled.
    press(1'b1, 1'b0);
    check("to_min_field", edit_field, 2'b10);
    press(1'b1, 1'b0);
    check("commit_valid", load_bus.load_valid, 1);
    check("commit_editing", editing, 0);
    check("commit_hrs", load_bus.load_hrs, 15);
    check("commit_min", load_bus.load_min, 30);
    step(10);
    check("stall_valid", load_bus.load_valid, 1);
    check("stall_hrs", load_bus.load_hrs, 15);
    check("stall_min", load_bus.load_min, 30);
    check("stall_no_xfer", xfers, 0);
    load_bus.load_ready = 1'b1;
    step(1);
    check("xfer_valid_low", load_bus.load_valid, 0);
    check("xfer_count", xfers, 1);
    check("xfer_idle_field", edit_field, 2'b00);
    load_bus.load_ready = 1'b0;

    // Wrap-around in both fields.
    cur_hrs = 8'd22;
    cur_min = 8'd58;
    press(1'b1, 1'b0);
    check("wrap_start_hrs", edit_hrs, 22);
    press(1'b0, 1'b1);
    check("wrap_hrs_23", edit_hrs, 23);
    press(1'b0, 1'b1);
    check("wrap_hrs_0", edit_hrs, 0);
    press(1'b1, 1'b0);
    check("wrap_start_min", edit_min, 58);
    press(1'b0, 1'b1);
    check("wrap_min_59", edit_min, 59);
    press(1'b0, 1'b1);
    check("wrap_min_0", edit_min, 0);

    // Ready held high before valid: single transfer, back to idle.
    load_bus.load_ready = 1'b1;
    press(1'b1, 1'b0);
    check("early_ready_valid", load_bus.load_valid, 0);
    check("early_ready_xfers", xfers, 2);
    check("early_ready_editing", editing, 0);
    load_bus.load_ready = 1'b0;

    // Out-of-range capture clamps to zero.
    cur_hrs = 8'd30;
    cur_min = 8'd70;
    press(1'b1, 1'b0);
    check("clamp_hrs", edit_hrs, 0);
    check("clamp_min", edit_min, 0);

    // Simultaneous mode and inc: mode wins.
    press(1'b1, 1'b1);
    check("both_field", edit_field, 2'b10);
    check("both_hrs", edit_hrs, 0);

    // Long inc hold in EDIT_MIN from 0.
    key_inc_n = 1'b0;
    step(18);
    step(36);
    key_inc_n = 1'b1;
    step(40);
`ifdef AUTO_REPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    check("hold_min", edit_min, exp_rep);

    // Asynchronous reset in the middle of COMMIT drops the load.
    press(1'b1, 1'b0);
    check("pre_reset_valid", load_bus.load_valid, 1);
    check("pre_reset_min", load_bus.load_min, exp_rep);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", load_bus.load_valid, 0);
    check("async_rst_editing", editing, 0);
    check("async_rst_min", load_bus.load_min, 0);
    step(2);
    reset_n = 1'b1;
    load_bus.load_ready = 1'b1;
    step(3);
    check("post_reset_valid", load_bus.load_valid, 0);
    check("post_reset_xfers", xfers, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
